usb_buff_scheduler: RTL and testbench

Write-side controller for the 256-byte USB ping-pong buffer. It arbitrates between two byte-stream requesters, ADC frame source 0 and status source 1, at packet granularity. Accepted bytes are written into the two 126-byte halves (base 0 and base 126), and the block toggles BUFFREADY_USBTRANS when a half fills. It tracks which halves the USB transceiver still owns and stalls writers rather than overwrite undrained data.

---
 rtl/usb_buff_pkg.sv | 21 ++
 rtl/usb_buff_halfptr.sv | 70 +++++++
 rtl/usb_buff_scheduler.sv | 107 ++++++++++
 tb/tb_usb_buff_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buff_pkg.sv
// Shared constants and types for the USB ping-pong buffer write-side scheduler.
package usb_buff_pkg;

  localparam int unsigned HALF_LEN   = 126;
  localparam int unsigned HALF2_BASE = 126;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  typedef logic req_idx_t;

  function automatic logic [7:0] half_addr(input logic wh, input logic [6:0] cnt);
    logic [7:0] base;
    base = wh ? 8'(HALF2_BASE) : '0;
    return base + {1'b0, cnt};
  endfunction

endpackage

// File: rtl/usb_buff_halfptr.sv
// Half-buffer bookkeeping: fill count, write half, transceiver ownership and
// the BUFFREADY toggle handed to the USB transceiver.
module usb_buff_halfptr
  import usb_buff_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       accept_i,
  input  logic       drain_done_i,
  output logic [7:0] addr_o,
  output logic       blocked_o,
  output logic       bufready_o
);

  logic [6:0] cnt_q, cnt_d;
  logic       wh_q, wh_d;
  logic [1:0] owned_q, owned_d;
  logic       dp_q, dp_d;
  logic       full_q, full_d;
  logic       bufready_q, bufready_d;
  logic       last_byte;

  assign last_byte  = (cnt_q == 7'(HALF_LEN - 1));
  assign addr_o     = half_addr(wh_q, cnt_q);
  assign blocked_o  = owned_q[wh_q];
  assign bufready_o = bufready_q;

  // Drain clear uses dp, fill set uses wh; both may land on the same edge.
  always_comb begin
    cnt_d      = cnt_q;
    wh_d       = wh_q;
    owned_d    = owned_q;
    dp_d       = dp_q;
    full_d     = 1'b0;
    bufready_d = bufready_q ^ full_q;
    if (drain_done_i && owned_q[dp_q]) begin
      owned_d[dp_q] = 1'b0;
      dp_d          = ~dp_q;
    end
    if (accept_i) begin
      if (last_byte) begin
        cnt_d          = '0;
        owned_d[wh_q]  = 1'b1;
        wh_d           = ~wh_q;
        full_d         = 1'b1;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      wh_q       <= 1'b0;
      owned_q    <= '0;
      dp_q       <= 1'b0;
      full_q     <= 1'b0;
      bufready_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wh_q       <= wh_d;
      owned_q    <= owned_d;
      dp_q       <= dp_d;
      full_q     <= full_d;
      bufready_q <= bufready_d;
    end
  end

endmodule

// File: rtl/usb_buff_scheduler.sv
// Packet-granular round-robin arbiter writing two byte streams into the
// 256-byte USB ping-pong buffer, stalling on halves still owned by the transceiver.
module usb_buff_scheduler
  import usb_buff_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENA,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic       LAST0,
  input  logic       LAST1,
  output logic       ACK0,
  output logic       ACK1,
  input  logic       DRAIN_DONE,
  output logic       WREN_USBBUFF,
  output logic [7:0] WADDR_USBBUFF,
  output logic [7:0] D_USBBUFF,
  output logic       BUFFREADY_USBTRANS,
  output logic       STALL
);

  state_e     state_q, state_d;
  req_idx_t   rr_q, rr_d;
  logic       accept0, accept1, accept;
  logic       blocked;
  logic [7:0] addr;
  logic       wren_q, wren_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] data_q, data_d;
  logic       stall_q, stall_d;

  assign accept0 = ENA && (state_q == GRANT0) && REQ0 && !blocked;
  assign accept1 = ENA && (state_q == GRANT1) && REQ1 && !blocked;
  assign accept  = accept0 || accept1;

  assign ACK0               = accept0;
  assign ACK1               = accept1;
  assign WREN_USBBUFF       = wren_q;
  assign WADDR_USBBUFF      = waddr_q;
  assign D_USBBUFF          = data_q;
  assign STALL              = stall_q;

  usb_buff_halfptr u_halfptr (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .accept_i     (accept),
    .drain_done_i (DRAIN_DONE),
    .addr_o       (addr),
    .blocked_o    (blocked),
    .bufready_o   (BUFFREADY_USBTRANS)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (ENA) begin
      case (state_q)
        IDLE: begin
          if (REQ0 && REQ1) begin
            state_d = rr_q ? GRANT1 : GRANT0;
            rr_d    = ~rr_q;
          end else if (REQ0) begin
            state_d = GRANT0;
          end else if (REQ1) begin
            state_d = GRANT1;
          end
        end
        GRANT0:  if (accept0 && LAST0) state_d = IDLE;
        GRANT1:  if (accept1 && LAST1) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wren_d  = accept;
    waddr_d = waddr_q;
    data_d  = data_q;
    if (accept) begin
      waddr_d = addr;
      data_d  = accept1 ? DATA1 : DATA0;
    end
    stall_d = blocked && (((state_q == GRANT0) && REQ0) || ((state_q == GRANT1) && REQ1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_usb_buff_scheduler.sv
// Scoreboard bench for usb_buff_scheduler: expected writes queued at ACK,
// compared when the registered write strobe appears.
module tb_usb_buff_scheduler;

  logic       CLK, RST_N, ENA;
  logic       REQ0, REQ1, LAST0, LAST1, DRAIN_DONE;
  logic [7:0] DATA0, DATA1;
  logic       ACK0, ACK1, WREN_USBBUFF, BUFFREADY_USBTRANS, STALL;
  logic [7:0] WADDR_USBBUFF, D_USBBUFF;

  int checks;
  int failures;

  logic [15:0] sb[$];
  int unsigned m_cnt;
  logic        m_wh;

  localparam int BUDGET = 300;

  usb_buff_scheduler dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .ENA                (ENA),
    .REQ0               (REQ0),
    .REQ1               (REQ1),
    .DATA0              (DATA0),
    .DATA1              (DATA1),
    .LAST0              (LAST0),
    .LAST1              (LAST1),
    .ACK0               (ACK0),
    .ACK1               (ACK1),
    .DRAIN_DONE         (DRAIN_DONE),
    .WREN_USBBUFF       (WREN_USBBUFF),
    .WADDR_USBBUFF      (WADDR_USBBUFF),
    .D_USBBUFF          (D_USBBUFF),
    .BUFFREADY_USBTRANS (BUFFREADY_USBTRANS),
    .STALL              (STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_accept(output logic [7:0] a);
    a = (m_wh ? 8'd126 : 8'd0) + 8'(m_cnt);
    m_cnt++;
    if (m_cnt == 126) begin
      m_cnt = 0;
      m_wh  = ~m_wh;
    end
  endtask

  // Leaves the bench aligned 1 time unit after a rising edge.
  task automatic apply_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0; ENA = 1'b1; REQ0 = 0; REQ1 = 0; LAST0 = 0; LAST1 = 0;
    DATA0 = '0; DATA1 = '0; DRAIN_DONE = 0;
    sb.delete(); m_cnt = 0; m_wh = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input int src, input logic [7:0] d, input logic last, output int waits);
    logic        got;
    logic [7:0]  ea;
    logic [15:0] exp;
    waits = 0;
    got   = 1'b0;
    if (src == 0) begin REQ0 = 1'b1; DATA0 = d; LAST0 = last; end
    else          begin REQ1 = 1'b1; DATA1 = d; LAST1 = last; end
    while (!got && waits <= BUDGET) begin
      #1;
      if ((src == 0) ? ACK0 : ACK1) begin
        got = 1'b1;
        model_accept(ea);
        sb.push_back({ea, d});
      end else begin
        waits++;
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout src=%0d data=%02h: no ACK within %0d cycles", src, d, BUDGET);
    end else begin
      exp = sb.pop_front();
      if (WREN_USBBUFF !== 1'b1 || WADDR_USBBUFF !== exp[15:8] || D_USBBUFF !== exp[7:0]) begin
        failures++;
        $display("FAIL write src=%0d: got wren=%b addr=%0d data=%02h, want wren=1 addr=%0d data=%02h",
                 src, WREN_USBBUFF, WADDR_USBBUFF, D_USBBUFF, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic send_pkt(input int src, input int n, input logic [7:0] d0, output int gaps);
    int w;
    gaps = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(src, d0 + 8'(i), (i == n - 1), w);
      if (i > 0 && w > 0) gaps++;
    end
    if (src == 0) begin REQ0 = 1'b0; LAST0 = 1'b0; end
    else          begin REQ1 = 1'b0; LAST1 = 1'b0; end
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    checks++;
    if ({ACK0, ACK1, WREN_USBBUFF, WADDR_USBBUFF, D_USBBUFF, BUFFREADY_USBTRANS, STALL} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b%b wren=%b addr=%0d d=%02h rdy=%b stall=%b, want all 0",
               ACK0, ACK1, WREN_USBBUFF, WADDR_USBBUFF, D_USBBUFF, BUFFREADY_USBTRANS, STALL);
    end
    checks++;
    if (dut.u_halfptr.owned_q !== 2'b00) begin
      failures++;
      $display("FAIL reset_owned: got %b want 00", dut.u_halfptr.owned_q);
    end
  endtask

  task automatic test_single();
    int gaps;
    apply_reset();
    send_pkt(0, 126, 8'h00, gaps);
    checks++;
    if (gaps != 0) begin failures++; $display("FAIL single_gaps: got %0d want 0", gaps); end
    checks++;
    if (BUFFREADY_USBTRANS !== 1'b0) begin
      failures++; $display("FAIL single_rdy_early: got %b want 0", BUFFREADY_USBTRANS);
    end
    @(posedge CLK); #1;
    checks++;
    if (BUFFREADY_USBTRANS !== 1'b1) begin
      failures++; $display("FAIL single_rdy_rise: got %b want 1", BUFFREADY_USBTRANS);
    end
    checks++;
    if (dut.u_halfptr.owned_q !== 2'b01) begin
      failures++; $display("FAIL single_owned: got %b want 01", dut.u_halfptr.owned_q);
    end
  endtask

  task automatic test_contention();
    int          idx0, idx1, pkts, cyc;
    int          order[$];
    logic        a0, a1, prev_last, l0, l1;
    logic [7:0]  ea;
    logic [15:0] exp;
    apply_reset();
    idx0 = 0; idx1 = 0; pkts = 0; cyc = 0; prev_last = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    while (pkts < 4 && cyc < 100) begin
      DATA0 = 8'h10 + 8'(idx0); LAST0 = (idx0 == 3);
      DATA1 = 8'h20 + 8'(idx1); LAST1 = (idx1 == 3);
      l0 = LAST0; l1 = LAST1;
      #1;
      a0 = ACK0; a1 = ACK1;
      if (a0 && a1) begin
        checks++; failures++; $display("FAIL both_ack: got ACK0=1 ACK1=1 want one-hot");
      end
      if (prev_last) begin
        checks++;
        if (a0 || a1) begin failures++; $display("FAIL bubble: got ack=%b%b want 00", a1, a0); end
      end
      if ((a0 && idx1 != 0) || (a1 && idx0 != 0)) begin
        checks++; failures++;
        $display("FAIL interleave: got ack0=%b ack1=%b with idx0=%0d idx1=%0d want no switch mid-packet", a0, a1, idx0, idx1);
      end
      if (a0) begin
        if (idx0 == 0) order.push_back(0);
        model_accept(ea); sb.push_back({ea, DATA0});
        idx0 = (idx0 + 1) % 4;
        if (l0) pkts++;
      end
      if (a1) begin
        if (idx1 == 0) order.push_back(1);
        model_accept(ea); sb.push_back({ea, DATA1});
        idx1 = (idx1 + 1) % 4;
        if (l1) pkts++;
      end
      prev_last = (a0 && l0) || (a1 && l1);
      @(posedge CLK); #1;
      if ((a0 || a1) && sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        if (WREN_USBBUFF !== 1'b1 || WADDR_USBBUFF !== exp[15:8] || D_USBBUFF !== exp[7:0]) begin
          failures++;
          $display("FAIL contention_write: got wren=%b addr=%0d data=%02h, want wren=1 addr=%0d data=%02h",
                   WREN_USBBUFF, WADDR_USBBUFF, D_USBBUFF, exp[15:8], exp[7:0]);
        end
      end
      cyc++;
    end
    REQ0 = 1'b0; REQ1 = 1'b0; LAST0 = 1'b0; LAST1 = 1'b0;
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      failures++;
      $display("FAIL grant_order: got %0d grants (%p) want 0,1,0,1", order.size(), order);
    end
  endtask

  task automatic test_overrun();
    int gaps, w;
    apply_reset();
    send_pkt(0, 126, 8'h00, gaps);
    send_pkt(0, 126, 8'h80, gaps);
    REQ0 = 1'b1; DATA0 = 8'hAA; LAST0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (ACK0 !== 1'b0) begin failures++; $display("FAIL overrun_ack cyc=%0d: got %b want 0", k, ACK0); end
      @(posedge CLK); #1;
    end
    checks++;
    if (STALL !== 1'b1) begin failures++; $display("FAIL overrun_stall: got %b want 1", STALL); end
    checks++;
    if (BUFFREADY_USBTRANS !== 1'b0) begin
      failures++; $display("FAIL overrun_rdy_fall: got %b want 0", BUFFREADY_USBTRANS);
    end
    DRAIN_DONE = 1'b1;
    @(posedge CLK); #1;
    DRAIN_DONE = 1'b0;
    send_byte(0, 8'hAA, 1'b1, w);
    REQ0 = 1'b0; LAST0 = 1'b0;
    checks++;
    if (w != 0) begin failures++; $display("FAIL stall_release: got %0d wait cycles want 0", w); end
  endtask

  task automatic test_span();
    int gaps;
    apply_reset();
    send_pkt(0, 120, 8'h00, gaps);
    send_pkt(0, 10, 8'h40, gaps);
    checks++;
    if (gaps != 0) begin failures++; $display("FAIL span_grant_held: got %0d gaps want 0", gaps); end
    checks++;
    if (BUFFREADY_USBTRANS !== 1'b1) begin
      failures++; $display("FAIL span_rdy: got %b want 1", BUFFREADY_USBTRANS);
    end
  endtask

  task automatic test_ena_drop();
    int w, gaps;
    apply_reset();
    for (int i = 0; i < 3; i++) send_byte(0, 8'h50 + 8'(i), 1'b0, w);
    ENA = 1'b0; DATA0 = 8'h53; LAST0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      DRAIN_DONE = (k == 2);
      #1;
      checks++;
      if (ACK0 !== 1'b0) begin failures++; $display("FAIL ena_ack cyc=%0d: got %b want 0", k, ACK0); end
      if (k > 0) begin
        checks++;
        if (WREN_USBBUFF !== 1'b0) begin failures++; $display("FAIL ena_wren cyc=%0d: got %b want 0", k, WREN_USBBUFF); end
      end
      @(posedge CLK); #1;
    end
    DRAIN_DONE = 1'b0; ENA = 1'b1;
    send_byte(0, 8'h53, 1'b0, w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL ena_resume: got %0d wait cycles want 0", w); end
    for (int i = 4; i < 8; i++) send_byte(0, 8'h50 + 8'(i), (i == 7), w);
    REQ0 = 1'b0; LAST0 = 1'b0;
    send_pkt(0, 118, 8'h00, gaps);
    checks++;
    if (dut.u_halfptr.owned_q !== 2'b01) begin
      failures++; $display("FAIL ena_owned_before: got %b want 01", dut.u_halfptr.owned_q);
    end
    ENA = 1'b0; DRAIN_DONE = 1'b1;
    @(posedge CLK); #1;
    DRAIN_DONE = 1'b0;
    checks++;
    if (dut.u_halfptr.owned_q !== 2'b00 || dut.u_halfptr.dp_q !== 1'b1) begin
      failures++;
      $display("FAIL ena_drain: got owned=%b dp=%b want owned=00 dp=1", dut.u_halfptr.owned_q, dut.u_halfptr.dp_q);
    end
    ENA = 1'b1;
  endtask

  task automatic test_reset_mid();
    int w, gaps;
    apply_reset();
    for (int i = 0; i < 50; i++) send_byte(0, 8'hC0 + 8'(i), 1'b0, w);
    DATA0 = 8'hFF;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({ACK0, ACK1, WREN_USBBUFF, WADDR_USBBUFF, D_USBBUFF, BUFFREADY_USBTRANS, STALL} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got ack=%b%b wren=%b addr=%0d d=%02h rdy=%b stall=%b, want all 0",
               ACK0, ACK1, WREN_USBBUFF, WADDR_USBBUFF, D_USBBUFF, BUFFREADY_USBTRANS, STALL);
    end
    REQ0 = 1'b0;
    sb.delete(); m_cnt = 0; m_wh = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    send_pkt(0, 4, 8'h11, gaps);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_cnt = 0; m_wh = 1'b0;
    RST_N = 1'b0; ENA = 1'b1; REQ0 = 0; REQ1 = 0; LAST0 = 0; LAST1 = 0;
    DATA0 = '0; DATA1 = '0; DRAIN_DONE = 0;
    test_reset();
    RST_N = 1'b1;
    test_single();
    test_contention();
    test_overrun();
    test_span();
    test_ena_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
